// File: rtl/ts_bus_pkg.sv
// ts_bus_pkg: shared state type and width helpers for the tri-state bus arbiter
package ts_bus_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int turn, input int hold);
        return $clog2(((turn > hold) ? turn : hold) + 1);
    endfunction

endpackage

// File: rtl/ts_bus_rr_pick.sv
// ts_bus_rr_pick: picks the first set request searching upward from ptr+1, wrapping modulo N
module ts_bus_rr_pick
    import ts_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w(N)
)(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_win,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    // scan farthest-first so the nearest set bit after the pointer is the last one kept
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_win = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_bus_arbiter.sv
// ts_bus_arbiter: round-robin owner of a shared tri-state bus with a TURN gap between owners; optional hold limit via TS_BUS_ARB_TIMEOUT_EN
module ts_bus_arbiter
    import ts_bus_pkg::*;
#(
    parameter int N           = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         oe,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 bus_busy,
    output logic                 timeout
);

    localparam int IW = id_w(N);
    localparam int CW = cnt_w(TURN_CYCLES, MAX_HOLD);
    localparam logic [CW-1:0] T_LAST = CW'(TURN_CYCLES - 1);

    state_t        r_state, w_state_n;
    logic [N-1:0]  r_oe, w_oe_n;
    logic [IW-1:0] r_gid, w_gid_n, r_ptr, w_ptr_n, w_win;
    logic [CW-1:0] r_tcnt, w_tcnt_n;
    logic          w_any, w_arb, w_release;
`ifdef TS_BUS_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] H_LAST = CW'(MAX_HOLD - 1);
    logic [CW-1:0] r_hcnt, w_hcnt_n;
    logic          r_to, w_to_n;
`endif

    ts_bus_rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // state register; reset drops every enable on the same edge with no turnaround
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_oe    <= '0;
            r_gid   <= '0;
            r_ptr   <= IW'(N - 1);
            r_tcnt  <= '0;
`ifdef TS_BUS_ARB_TIMEOUT_EN
            r_hcnt  <= '0;
            r_to    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_oe    <= w_oe_n;
            r_gid   <= w_gid_n;
            r_ptr   <= w_ptr_n;
            r_tcnt  <= w_tcnt_n;
`ifdef TS_BUS_ARB_TIMEOUT_EN
            r_hcnt  <= w_hcnt_n;
            r_to    <= w_to_n;
`endif
        end
    end

    // next state: arbitrate from IDLE or the last TURN cycle, release into TURN when the owner lets go
    always_comb begin
        w_state_n = r_state;
        w_oe_n    = r_oe;
        w_gid_n   = r_gid;
        w_ptr_n   = r_ptr;
        w_tcnt_n  = r_tcnt;
        w_arb     = 1'b0;
        w_release = 1'b0;
`ifdef TS_BUS_ARB_TIMEOUT_EN
        w_hcnt_n  = r_hcnt;
        w_to_n    = 1'b0;
`endif
        case (r_state)
            ST_IDLE:  w_arb = 1'b1;
            ST_DRIVE: begin
                if (!req[r_gid]) begin
                    w_release = 1'b1;
                end
`ifdef TS_BUS_ARB_TIMEOUT_EN
                else if (r_hcnt == H_LAST) begin
                    w_release = 1'b1;
                    w_to_n    = 1'b1;
                end else begin
                    w_hcnt_n  = r_hcnt + 1'b1;
                end
`endif
            end
            ST_TURN: begin
                w_arb    = (r_tcnt == T_LAST);
                w_tcnt_n = (r_tcnt == T_LAST) ? r_tcnt : r_tcnt + 1'b1;
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_release) begin
            w_state_n = ST_TURN;
            w_oe_n    = '0;
            w_tcnt_n  = '0;
        end
        if (w_arb) begin
            w_state_n = w_any ? ST_DRIVE : ST_IDLE;
            w_oe_n    = w_any ? ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;
            w_gid_n   = w_any ? w_win : r_gid;
            w_ptr_n   = w_any ? w_win : r_ptr;
            w_tcnt_n  = '0;
`ifdef TS_BUS_ARB_TIMEOUT_EN
            w_hcnt_n  = '0;
`endif
        end
    end

    assign oe       = r_oe;
    assign grant_id = r_gid;
    assign bus_busy = |r_oe;
`ifdef TS_BUS_ARB_TIMEOUT_EN
    assign timeout  = r_to;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_ts_bus_arbiter.sv
// tb_ts_bus_arbiter: table vectors, corner sequences and random traffic against a priority-list model
module tb_ts_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
`ifdef TS_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int owner;
        int gap;
        int hold;
        bit to;
        int order[N];
    } mdl_t;

    typedef struct {
        bit           rn;
        logic [N-1:0] rq;
        logic [N-1:0] oe;
        int           gid;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] oe1, oe3;
    logic [1:0]   gid1, gid3;
    logic         busy1, busy3, to1, to3;
    int           n_pass = 0;
    int           n_total = 0;
    mdl_t         m1, m3;
    vec_t         tbl[$];

    always #5 clk = ~clk;

    ts_bus_arbiter #(.N(N), .TURN_CYCLES(1), .MAX_HOLD(MH)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .oe(oe1),
        .grant_id(gid1), .bus_busy(busy1), .timeout(to1)
    );

    ts_bus_arbiter #(.N(N), .TURN_CYCLES(3), .MAX_HOLD(MH)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .oe(oe3),
        .grant_id(gid3), .bus_busy(busy3), .timeout(to3)
    );

    // Reference: owner is picked from a priority list; the winner is rotated to the back.
    // gap counts fully elapsed released cycles; arbitration needs at least tc of them.
    function automatic mdl_t step(input mdl_t m, input bit rn, input logic [N-1:0] rq, input int tc);
        mdl_t s;
        int w, t;
        s = m;
        s.to = 1'b0;
        if (!rn) begin
            s.owner = -1;
            s.gap = tc;
            s.hold = 0;
            for (int i = 0; i < N; i++) s.order[i] = i;
            return s;
        end
        if (s.owner >= 0) begin
            if (!rq[s.owner]) begin
                s.owner = -1;
                s.gap = 0;
            end else if (TO_EN && s.hold == MH) begin
                s.owner = -1;
                s.gap = 0;
                s.to = 1'b1;
            end else begin
                s.hold++;
            end
        end else begin
            if (s.gap < tc) s.gap++;
            if (s.gap >= tc) begin
                w = -1;
                for (int i = 0; i < N; i++) if (w < 0 && rq[s.order[i]]) w = s.order[i];
                if (w >= 0) begin
                    s.owner = w;
                    s.hold = 1;
                    while (s.order[N-1] != w) begin
                        t = s.order[0];
                        for (int i = 0; i < N - 1; i++) s.order[i] = s.order[i+1];
                        s.order[N-1] = t;
                    end
                end
            end
        end
        return s;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_model(input string nm, input mdl_t m, input logic [N-1:0] o,
                             input logic [1:0] g, input logic b, input logic t);
        logic [N-1:0] eo;
        eo = (m.owner >= 0) ? (N'(1) << m.owner) : '0;
        chk({nm, "_oe"}, int'(o), int'(eo));
        chk({nm, "_busy"}, int'(b), int'(m.owner >= 0));
        chk({nm, "_timeout"}, int'(t), int'(m.to));
        chk({nm, "_onehot"}, int'($countones(o) <= 1), 1);
        if (m.owner >= 0) chk({nm, "_gid"}, int'(g), m.owner);
    endtask

    task automatic tick(input bit rn, input logic [N-1:0] rq);
        rst_n = rn;
        req = rq;
        @(posedge clk);
        m1 = step(m1, rn, rq, 1);
        m3 = step(m3, rn, rq, 3);
        #1;
        chk_model("m1", m1, oe1, gid1, busy1, to1);
        chk_model("m3", m3, oe3, gid3, busy3, to3);
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] exp_oe;
        bit rn;
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b0001, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b0110, 4'b0010, 1});
        tbl.push_back('{1'b1, 4'b0110, 4'b0010, 1});
        tbl.push_back('{1'b1, 4'b0100, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2});
        tbl.push_back('{1'b1, 4'b0100, 4'b0100, 2});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 0});
        tbl.push_back('{1'b1, 4'b1110, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 1});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010, 1});
        tbl.push_back('{1'b1, 4'b1101, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100, 2});
        tbl.push_back('{1'b1, 4'b1011, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 3});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000, 3});
        tbl.push_back('{1'b1, 4'b0111, 4'b0000, 0});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 0});
        foreach (tbl[i]) begin
            tick(tbl[i].rn, tbl[i].rq);
            chk("tbl_oe", int'(oe1), int'(tbl[i].oe));
            chk("tbl_busy", int'(busy1), int'(|tbl[i].oe));
            chk("tbl_timeout", int'(to1), 0);
            if (tbl[i].oe != 0) chk("tbl_gid", int'(gid1), tbl[i].gid);
        end
        tick(1'b0, 4'b0000);
        tick(1'b1, 4'b0100);
        chk("turn3_grant", int'(oe3), 4'b0100);
        tick(1'b1, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'b1000);
            exp_oe = (i == 3) ? 4'b1000 : 4'b0000;
            chk("turn3_gap", int'(oe3), int'(exp_oe));
        end
`ifdef TS_BUS_ARB_TIMEOUT_EN
        tick(1'b0, 4'b0000);
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, 4'b0011);
            exp_oe = (i < 4) ? 4'b0001 : (i == 4 || i == 9) ? 4'b0000 : (i < 9) ? 4'b0010 : 4'b0001;
            chk("to_oe", int'(oe1), int'(exp_oe));
            chk("to_pulse", int'(to1), int'(i == 4 || i == 9));
        end
`endif
        tick(1'b0, 4'b0000);
        rq = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            rn = ($urandom_range(0, 79) != 0);
            tick(rn, rq);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ts_bus_arbiter.md
Name: ts_bus_arbiter

Overview:
- Grants exclusive drive rights on one shared tri-state bus (wired pad net) to one of N requesters.
- Each oe[i] output connects directly to the output-enable of requester i's tri-state pad.
- Guarantees the bus never has more than one enabled driver.
- Inserts a configurable all-released turnaround between owners, so no two pads drive the net in the same cycle.

Parameters:
- N, 4, number of requesters; N >= 2.
- TURN_CYCLES, 1, cycles with all oe low between two ownerships; must be >= 1.
- MAX_HOLD, 16, maximum consecutive DRIVE cycles per grant; only used when the optional feature is compiled in.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- req, input, N, request vector; requester i holds req[i] high for as long as it wants the bus.
- oe, output, N, one-hot-or-zero pad output enables, registered.
- grant_id, output, $clog2(N), index of the current owner; valid only while bus_busy = 1.
- bus_busy, output, 1, high exactly when some oe bit is high.
- timeout, output, 1, one-cycle pulse when an ownership is forcibly ended.

Behaviour:
- Reset (rst_n = 0 at an edge): state = IDLE, oe = 0, grant_id = 0, bus_busy = 0, timeout = 0, rr_ptr = N-1 (requester 0 has highest priority first), turnaround and hold counters = 0.
- Reset mid-DRIVE releases oe on that same edge; no turnaround is applied.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If req != 0, pick the winner: the first set bit searching upward from rr_ptr+1, wrapping modulo N.
  - Next edge: state = DRIVE, oe[winner] = 1, grant_id = winner, rr_ptr = winner.
  - Grant latency is 1 cycle from req sampled high to oe high.
- DRIVE:
  - Stay while req[grant_id] = 1.
  - If req[grant_id] is sampled low: next edge oe = 0, state = TURN, turnaround counter = 0.
  - Release latency is 1 cycle.
  - Requests from other requesters are ignored during DRIVE; there is no preemption.
- TURN:
  - oe = 0 for exactly TURN_CYCLES cycles.
  - On the last TURN cycle, arbitrate as in IDLE: winner goes to DRIVE on the next edge; if req == 0, go to IDLE.
  - A requester that asserts during TURN is eligible at the arbitration point. The previous owner is lowest priority because rr_ptr equals its index.
- Simultaneous events:
  - Owner drops req in the same cycle others raise theirs: the normal release-then-TURN path applies.
  - Requests arriving in the reset cycle are ignored.
- Invariants, checked always:
  - $countones(oe) <= 1.
  - Between two different owners there are at least TURN_CYCLES consecutive cycles with oe == 0.
  - bus_busy == |oe.
  - grant_id matches the index of the set oe bit.
- Without the optional feature, timeout is tied to 0 and an owner may hold the bus indefinitely.

Optional Feature:
- Macro: TS_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to DRIVE and increments each DRIVE cycle.
  - When the owner has held oe for MAX_HOLD cycles with req still high: next edge oe = 0, state = TURN, timeout = 1 for one cycle.
  - A still-requesting owner re-competes under round-robin and can regain the bus only if no other req is set at arbitration.
- Undefined: there is no hold counter and the timeout output is constant 0.

Decomposition:
- Package ts_bus_pkg holds:
  - the state enum (IDLE, DRIVE, TURN);
  - the ID-width localparam helper;
  - the turnaround and hold counter width rules (clog2 of max(TURN_CYCLES, MAX_HOLD)+1).
- One sub-module, ts_bus_rr_pick: combinational round-robin picker (req, rr_ptr -> winner, any).
- The FSM, counters and registered oe stay in ts_bus_arbiter.

Test Plan (defaults, N = 4, TURN_CYCLES = 1):
- Single requester: req = 0001 at cycle 0 -> oe = 0001, bus_busy = 1 at cycle 1; req drops at cycle 5 -> oe = 0000 at cycle 6 and bus stays idle.
- Contention: req = 0110 from reset -> oe = 0010 first. Requester 1 drops -> one cycle oe = 0000 -> oe = 0100. Driver count on the bus net is never > 1.
- Fairness: req = 1111 held, each owner drops after 2 cycles and re-raises -> grant order 0,1,2,3,0. Each grant is separated by exactly one idle-oe cycle.
- Turnaround: TURN_CYCLES = 3, owner 2 releases with req = 1000 pending -> oe = 0000 for 3 cycles, then oe = 1000.
- Reset mid-drive: oe = 0100, rst_n = 0 for 1 cycle -> oe = 0000 on that edge. With req = 1111 after reset release, requester 0 wins.
- Timeout (macro defined, MAX_HOLD = 4): req = 0011 held constantly -> oe = 0001 for 4 cycles, timeout pulse, 1 idle cycle, oe = 0010 for 4 cycles, then back to 0001.
